adat_transmitter: RTL and testbench
===================================

Name: adat_transmitter

Overview:
Serialises one 8-channel, 24-bit ADAT frame per sample period onto an optical TX line using NRZI coding. It is instantiated twice under main, once for channels 1-8 and once for channels 9-16, driving adat_out_1_o and adat_out_2_o. It is the transmit counterpart of the ADAT receivers. Audio and user bits arrive through a one-deep valid/ready holding buffer, and the block emits a frame-start strobe for word-clock alignment.

Parameters:
CLKS_PER_BIT, 2, clk_i cycles per ADAT bit cell (minimum 1). Use 2 with the 512*fs master clock.

Ports:
clk_i  in  1  master clock (CLKS_PER_BIT*256*fs)
rst_i  in  1  asynchronous, active-high reset
en_i  in  1  transmit enable
ch_data_i  in  192  channel k in bits [24k+23:24k]; k=0 is sent first
user_i  in  4  user bits U3..U0, captured together with ch_data_i
ch_valid_i  in  1  producer has a frame of samples
ch_ready_o  out  1  holding buffer is empty; a transfer happens on valid&ready
adat_o  out  1  NRZI line output
frame_start_o  out  1  one-cycle pulse per frame start
underrun_o  out  1  one-cycle pulse when a frame is sent without fresh data

Behaviour:
- Reset values:
  - adat_o=0, frame_start_o=0, underrun_o=0.
  - Divider and bit counter = 0.
  - Holding buffer empty, so ch_ready_o=1.
  - Shift/frame register = 0.
- Frame layout, 256 bits, bit index b sent in order:
  - b0-9 = 0 (sync).
  - b10 = 1.
  - b11-14 = U3..U0.
  - For n=0..47: b15+5n = 1, then b16+5n..b19+5n = nibble n, MSB first.
  - Nibble n belongs to channel n/6, taking bits [23-4(n%6) -: 4].
  - b255 = 1.
- Timing:
  - A divider counts 0..CLKS_PER_BIT-1. A bit cell starts on each edge where en_i=1 and div==0.
  - bit_cnt advances after the last divider cycle and wraps 255→0.
- NRZI:
  - At each bit-cell start edge, adat_o <= adat_o XOR bit[bit_cnt].
  - adat_o is registered and holds for the full cell. A '1' toggles the line; a '0' holds it.
- Frame-start event (en_i & div==0 & bit_cnt==0):
  - If the holding buffer is full: frame register <= holding contents, holding becomes empty.
  - If the holding buffer is empty: frame register <= all-zero data and user bits, and underrun_o pulses for 1 cycle.
  - frame_start_o pulses for 1 cycle in both cases. Both pulses are registered and visible in the cycle after the event edge.
  - Bit 0 is constant 0, so the load and the first NRZI update share the edge safely.
- Handshake:
  - ch_ready_o = !holding_full.
  - On the edge with valid&ready, the holding buffer captures ch_data_i and user_i.
  - Data captured before a frame-start event is transmitted in that frame.
- Simultaneous events:
  - Transfer on the frame-start edge with holding empty: the underrun frame is sent, and the new data lands in holding for the next frame.
  - Holding full at frame start: the buffer is drained and ch_ready_o rises on the next cycle. No transfer happens on that edge because ready was 0.
- en_i low:
  - div and bit_cnt are cleared to 0 at each edge; adat_o holds its level.
  - No frame_start_o or underrun_o pulses; the holding buffer and handshake keep working.
  - When en_i rises, a new frame starts on that edge.
- Reset mid-frame: everything returns to reset values immediately, the holding contents are discarded, and transmission restarts at bit 0.
- Width rules: bit_cnt is 8 bits; the divider is $clog2(CLKS_PER_BIT) bits, minimum 1.

Decomposition:
- adat_pkg:
  - ADAT_FRAME_BITS=256, ADAT_SYNC_ZEROS=10, ADAT_CHANNELS=8, ADAT_SAMPLE_W=24, ADAT_NIBBLES=48.
  - typedef adat_sample_t (logic [23:0]).
  - typedef adat_frame_t (struct of user nibble and sample array).
  - A function mapping bit index to frame bit. The ADAT receivers share this package.
- One sub-module, adat_tx_nrzi:
  - Owns the divider, bit counter, bit-cell strobe and NRZI output register.
  - Exposes bit_cnt and the frame-start event to the parent, which owns the buffers and bit selection.

Test Plan:
- Reset release with en_i=1 and no valid: frame_start_o pulses every 512 cycles with underrun_o. Decoding adat_o (transition = 1) gives 10 zeros, 1, 0000, then 48×"10000", then 1.
- Load ch0=0xABCDEF, others 0, user=0xA before a frame start: the next frame decodes to b11-14=1010 and b15-44 = 1 1010 1 1011 1 1100 1 1101 1 1110 1 1111. No underrun pulse.
- Hold ch_valid_i=1 continuously with an incrementing pattern: every frame carries a distinct sample set with no skips or repeats. ch_ready_o is low for all but 1 cycle per frame, and underrun_o never pulses.
- Assert valid exactly on the frame-start edge with holding empty: underrun_o=1 and the current frame is all zeros. The data appears in the following frame.
- Drop en_i at bit 100: adat_o frozen, no pulses. Re-enable: frame_start_o pulse, and a full sync preamble is observed.
- Assert rst_i mid-frame with holding full: adat_o=0 and ch_ready_o=1 immediately. The first frame after release is an underrun frame.

Source files
------------

// File: rtl/adat_pkg.sv
// ADAT frame constants, frame types and bit-index mapping.
// Shared by the ADAT transmitter and receivers.
package adat_pkg;

  localparam int ADAT_FRAME_BITS = 256;
  localparam int ADAT_SYNC_ZEROS = 10;
  localparam int ADAT_CHANNELS   = 8;
  localparam int ADAT_SAMPLE_W   = 24;
  localparam int ADAT_NIBBLES    = 48;

  typedef logic [ADAT_SAMPLE_W-1:0] adat_sample_t;

  typedef struct packed {
    logic [3:0]                       user;
    adat_sample_t [ADAT_CHANNELS-1:0] ch;
  } adat_frame_t;

  function automatic logic adat_frame_bit(
    input adat_frame_t f,
    input logic [7:0]  idx
  );
    logic       res;
    int         b;
    int         off;
    int         n;
    int         r;
    logic [1:0] ui;
    logic [2:0] k;
    logic [4:0] sb;
    res = 1'b0;
    b   = int'(idx);
    ui  = '0;
    k   = '0;
    sb  = '0;
    if (b == ADAT_SYNC_ZEROS || b == ADAT_FRAME_BITS - 1) begin
      res = 1'b1;
    end else if (b >= 11 && b <= 14) begin
      ui  = 2'(14 - b);
      res = f.user[ui];
    end else if (b >= 15) begin
      // 5-bit groups: a '1' separator followed by one nibble, MSB first
      off = b - 15;
      n   = off / 5;
      r   = off % 5;
      if (r == 0) begin
        res = 1'b1;
      end else begin
        k   = 3'(n / 6);
        sb  = 5'(23 - 4 * (n % 6) - (r - 1));
        res = f.ch[k][sb];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/adat_tx_nrzi.sv
// ADAT bit-cell timing and NRZI line register.
// Drives the bit counter and flags the frame-start edge.
module adat_tx_nrzi
  import adat_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [7:0] bit_cnt_o,
  output logic       frame_evt_o,
  output logic       adat_o
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BCW   = $clog2(ADAT_FRAME_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic             adat_q, adat_d;
  logic             cell_start;

  assign cell_start  = en_i && (div_q == '0);
  assign frame_evt_o = cell_start && (bit_cnt_q == '0);
  assign bit_cnt_o   = bit_cnt_q;
  assign adat_o      = adat_q;

  always_comb begin
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    adat_d    = adat_q;
    if (!en_i) begin
      div_d     = '0;
      bit_cnt_d = '0;
    end else begin
      if (div_q == DIV_LAST) begin
        div_d     = '0;
        bit_cnt_d = bit_cnt_q + BCW'(1);
      end else begin
        div_d = div_q + DIV_W'(1);
      end
      if (cell_start) begin
        adat_d = adat_q ^ bit_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q     <= '0;
      bit_cnt_q <= '0;
      adat_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      adat_q    <= adat_d;
    end
  end

endmodule

// File: rtl/adat_transmitter.sv
// ADAT optical transmitter: 8 channels x 24 bits per frame, NRZI.
// One-deep holding buffer feeds the frame register at each frame start.
module adat_transmitter
  import adat_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [191:0] ch_data_i,
  input  logic [3:0]   user_i,
  input  logic         ch_valid_i,
  output logic         ch_ready_o,
  output logic         adat_o,
  output logic         frame_start_o,
  output logic         underrun_o
);

  adat_frame_t hold_q, hold_d;
  adat_frame_t frame_q, frame_d;
  logic        hold_full_q, hold_full_d;
  logic        frame_start_q, frame_start_d;
  logic        underrun_q, underrun_d;
  logic [7:0]  bit_cnt;
  logic        frame_evt;
  logic        bit_sel;
  logic        xfer;

  assign ch_ready_o    = !hold_full_q;
  assign xfer          = ch_valid_i && ch_ready_o;
  assign frame_start_o = frame_start_q;
  assign underrun_o    = underrun_q;

  // bit 0 is always 0, so loading the frame on the same edge is safe
  assign bit_sel = adat_frame_bit(frame_q, bit_cnt);

  adat_tx_nrzi #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_nrzi (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .bit_i      (bit_sel),
    .bit_cnt_o  (bit_cnt),
    .frame_evt_o(frame_evt),
    .adat_o     (adat_o)
  );

  always_comb begin
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    frame_d       = frame_q;
    frame_start_d = frame_evt;
    underrun_d    = 1'b0;
    if (frame_evt) begin
      if (hold_full_q) begin
        frame_d     = hold_q;
        hold_full_d = 1'b0;
      end else begin
        frame_d    = '0;
        underrun_d = 1'b1;
      end
    end
    if (xfer) begin
      hold_d.user = user_i;
      hold_d.ch   = ch_data_i;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      frame_q       <= '0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      frame_q       <= frame_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

endmodule

// File: tb/tb_adat_transmitter.sv
// Bench for adat_transmitter: decodes the NRZI line and compares
// each frame with a model built from the frame layout rules.
module tb_adat_transmitter;

  localparam int CPB = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         valid;
  logic [191:0] data;
  logic [3:0]   user;
  logic         ready;
  logic         adat;
  logic         fs;
  logic         ur;

  int unsigned  cyc = 0;
  int           compared = 0;
  int           mismatched = 0;

  typedef struct {
    logic [23:0] ch0;
    logic [3:0]  u;
    logic [33:0] exp_bits;
  } vec_t;

  typedef struct {
    int unsigned  c;
    logic [3:0]   u;
    logic [191:0] d;
  } xfer_t;

  xfer_t q[$];
  bit    run;
  int    mode;

  adat_transmitter #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .ch_data_i    (data),
    .user_i       (user),
    .ch_valid_i   (valid),
    .ch_ready_o   (ready),
    .adat_o       (adat),
    .frame_start_o(fs),
    .underrun_o   (ur)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [255:0] got,
                     input logic [255:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic logic [255:0] build_frame(input logic [3:0] u,
                                               input logic [191:0] d);
    logic [255:0] f;
    int p;
    f = '0;
    p = 10;
    f[p] = 1'b1;
    p++;
    for (int i = 3; i >= 0; i--) begin
      f[p] = u[i];
      p++;
    end
    for (int k = 0; k < 8; k++) begin
      for (int s = 0; s < 6; s++) begin
        f[p] = 1'b1;
        p++;
        for (int j = 0; j < 4; j++) begin
          f[p] = d[24*k + 23 - 4*s - j];
          p++;
        end
      end
    end
    f[p] = 1'b1;
    return f;
  endfunction

  task automatic wait_pulse();
    bit seen;
    seen = 0;
    for (int n = 0; n < 3000 && !seen; n++) begin
      @(negedge clk);
      if (fs) seen = 1;
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("FAIL wait_pulse: got no frame_start_o, required one");
    end
  endtask

  task automatic capture(output logic [255:0] bits, output logic urv,
                         output int unsigned ecyc);
    logic prev;
    logic lvl;
    bit   seen;
    bits = '0;
    urv  = 1'b0;
    ecyc = 0;
    prev = adat;
    seen = 0;
    for (int n = 0; n < 3000 && !seen; n++) begin
      @(negedge clk);
      if (fs) seen = 1;
      else prev = adat;
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("FAIL capture: got no frame_start_o, required one");
      return;
    end
    bits[0] = adat ^ prev;
    urv     = ur;
    ecyc    = cyc;
    prev    = adat;
    for (int b = 1; b < 256; b++) begin
      repeat (CPB) @(negedge clk);
      lvl     = adat;
      bits[b] = lvl ^ prev;
      prev    = lvl;
    end
  endtask

  task automatic producer();
    bit           vd;
    bit           rdy_prev;
    logic [191:0] dd;
    logic [3:0]   uu;
    vd       = 0;
    rdy_prev = 0;
    dd       = '0;
    uu       = '0;
    while (run) begin
      @(negedge clk);
      if (vd && rdy_prev) begin
        q.push_back('{cyc, uu, dd});
        vd = 0;
      end
      if (!vd && run && (mode == 0 || $urandom_range(0, 899) == 0)) begin
        vd = 1;
        dd = {$urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom()};
        uu = 4'($urandom());
      end
      rdy_prev = ready;
      valid    = vd;
      data     = dd;
      user     = uu;
    end
    valid = 1'b0;
  endtask

  task automatic consumer(input int nframes, input string tag);
    logic [255:0] bits;
    logic [255:0] expf;
    logic         urv;
    logic         expu;
    int unsigned  ecyc;
    xfer_t        t;
    for (int i = 0; i < nframes; i++) begin
      capture(bits, urv, ecyc);
      if (q.size() > 0 && q[0].c < ecyc) begin
        t    = q.pop_front();
        expf = build_frame(t.u, t.d);
        expu = 1'b0;
      end else begin
        expf = build_frame(4'h0, 192'h0);
        expu = 1'b1;
      end
      chk({tag, "_frame"}, bits, expf);
      chk({tag, "_underrun"}, 256'(urv), 256'(expu));
    end
    run = 0;
  endtask

  vec_t         vecs[4];
  logic [255:0] bits;
  logic [255:0] zf;
  logic         urv;
  logic         lvl;
  bit           bad;
  int unsigned  ecyc, ecyc2, en_cyc;
  logic [191:0] dsim;

  initial begin
    vecs[0] = '{24'hABCDEF, 4'hA,
                34'b1010_11010_11011_11100_11101_11110_11111};
    vecs[1] = '{24'h000000, 4'h0,
                34'b0000_10000_10000_10000_10000_10000_10000};
    vecs[2] = '{24'hFFFFFF, 4'hF,
                34'b1111_11111_11111_11111_11111_11111_11111};
    vecs[3] = '{24'h123456, 4'h5,
                34'b0101_10001_10010_10011_10100_10101_10110};
    zf    = build_frame(4'h0, 192'h0);
    rst   = 1'b1;
    en    = 1'b0;
    valid = 1'b0;
    data  = '0;
    user  = '0;
    run   = 0;
    mode  = 0;
    repeat (3) @(negedge clk);
    chk("rst_adat", 256'(adat), 256'(0));
    chk("rst_frame_start", 256'(fs), 256'(0));
    chk("rst_underrun", 256'(ur), 256'(0));
    chk("rst_ready", 256'(ready), 256'(1));

    // idle frames: underrun every 512 cycles, empty payload
    rst = 1'b0;
    en  = 1'b1;
    capture(bits, urv, ecyc);
    chk("idle_frame0", bits, zf);
    chk("idle_underrun0", 256'(urv), 256'(1));
    capture(bits, urv, ecyc2);
    chk("idle_frame1", bits, zf);
    chk("idle_period", 256'(ecyc2 - ecyc), 256'(512));

    foreach (vecs[i]) begin
      wait_pulse();
      valid = 1'b1;
      data  = {168'h0, vecs[i].ch0};
      user  = vecs[i].u;
      @(negedge clk);
      valid = 1'b0;
      capture(bits, urv, ecyc);
      chk($sformatf("vec%0d_b11_44", i), 256'(bits[44:11]),
          256'({<<{vecs[i].exp_bits}}));
      chk($sformatf("vec%0d_frame", i), bits,
          build_frame(vecs[i].u, {168'h0, vecs[i].ch0}));
      chk($sformatf("vec%0d_underrun", i), 256'(urv), 256'(0));
    end

    // transfer lands on the frame-start edge with holding empty
    dsim = {$urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom()};
    fork
      capture(bits, urv, ecyc);
      begin
        @(negedge clk);
        valid = 1'b1;
        data  = dsim;
        user  = 4'h9;
        @(negedge clk);
        valid = 1'b0;
      end
    join
    chk("simul_underrun", 256'(urv), 256'(1));
    chk("simul_frame_zero", bits, zf);
    capture(bits, urv, ecyc);
    chk("simul_next_frame", bits, build_frame(4'h9, dsim));
    chk("simul_next_underrun", 256'(urv), 256'(0));

    // drop enable around bit 100, then re-enable
    wait_pulse();
    repeat (201) @(negedge clk);
    en  = 1'b0;
    lvl = adat;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (adat !== lvl || fs !== 1'b0 || ur !== 1'b0) bad = 1;
    end
    chk("en_low_quiet", 256'(bad), 256'(0));
    en_cyc = 0;
    fork
      capture(bits, urv, ecyc);
      begin
        @(negedge clk);
        en     = 1'b1;
        en_cyc = cyc;
      end
    join
    chk("reenable_start_cycle", 256'(ecyc), 256'(en_cyc + 1));
    chk("reenable_frame", bits, zf);
    chk("reenable_underrun", 256'(urv), 256'(1));

    // reset mid-frame while the holding buffer is full
    wait_pulse();
    valid = 1'b1;
    data  = {$urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom()};
    user  = 4'h6;
    @(negedge clk);
    valid = 1'b0;
    chk("hold_full_ready", 256'(ready), 256'(0));
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_adat", 256'(adat), 256'(0));
    chk("midrst_ready", 256'(ready), 256'(1));
    chk("midrst_frame_start", 256'(fs), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    capture(bits, urv, ecyc);
    chk("postrst_frame", bits, zf);
    chk("postrst_underrun", 256'(urv), 256'(1));

    // randomized traffic against the frame-queue model
    q.delete();
    mode = 0;
    run  = 1;
    fork
      producer();
      consumer(5, "cont");
    join
    q.delete();
    repeat (3) @(negedge clk);
    wait_pulse();
    mode = 1;
    run  = 1;
    fork
      producer();
      consumer(6, "sparse");
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
